instr_fetch_unit: RTL

//  Consumer side of the program counter: reads newPC, fetches the instruction

---
 rtl/instr_fetch_unit_if.sv | 24 ++
 rtl/instr_fetch_unit.sv | 123 ++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read bus: address/request from the fetch unit,
// data/ready back from memory.
interface instr_fetch_unit_if;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_ready;
  logic [31:0] mem_data;

  // Fetch unit side: issues the request, receives the instruction word.
  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_ready,
    input  mem_data
  );

  // Memory side: sees the request, returns data with ready.
  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_ready,
    output mem_data
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads the PC, fetches one instruction word over a
// ready handshake, holds it in IR until decode accepts it, pulses IncPC once
// per completed fetch, and raises a sticky fault if memory never answers.
module instr_fetch_unit #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 5
) (
  input  logic                 clock,
  input  logic                 clear_n,
  input  logic                 run,
  input  logic                 flush,
  input  logic [31:0]          pc_in,
  instr_fetch_unit_if.master   mem,
  output logic [31:0]          ir_out,
  output logic [31:0]          ir_pc,
  output logic                 ir_valid,
  input  logic                 ir_accept,
  output logic                 IncPC,
  output logic                 fault
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FAULT} state_t;

  // Counter value at which one more unanswered FETCH cycle means timeout.
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(WAIT_LIMIT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]      ir_out_q, ir_out_d;
  logic [31:0]      ir_pc_q, ir_pc_d;
  logic             ir_valid_q, ir_valid_d;
  logic             incpc_q, incpc_d;
  logic             fault_q, fault_d;

  // State and datapath registers; clear_n returns everything to idle at once.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      ir_out_q   <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      incpc_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ir_out_q   <= ir_out_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      incpc_q    <= incpc_d;
      fault_q    <= fault_d;
    end
  end

  // Next-state logic; flush overrides ready, accept and timeout so a
  // discarded fetch never loads IR nor increments the PC.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    ir_out_d   = ir_out_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    incpc_d    = 1'b0;
    fault_d    = fault_q;

    if (flush) begin
      state_d    = IDLE;
      ir_valid_d = 1'b0;
      wait_cnt_d = '0;
      fault_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (run) begin
            state_d    = FETCH;
            wait_cnt_d = '0;
          end
        end
        FETCH: begin
          if (mem.mem_ready) begin
            ir_out_d   = mem.mem_data;
            ir_pc_d    = pc_in;
            ir_valid_d = 1'b1;
            incpc_d    = 1'b1;
            wait_cnt_d = '0;
            state_d    = HOLD;
          end else if (wait_cnt_q == LAST_WAIT) begin
            fault_d    = 1'b1;
            wait_cnt_d = '0;
            state_d    = FAULT;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end
        HOLD: begin
          if (ir_accept) begin
            ir_valid_d = 1'b0;
            wait_cnt_d = '0;
            state_d    = run ? FETCH : IDLE;
          end
        end
        FAULT: begin
          ir_valid_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Memory request is only ever presented while fetching.
  assign mem.mem_rd   = (state_q == FETCH);
  assign mem.mem_addr = (state_q == FETCH) ? pc_in : 32'h0;

  assign ir_out   = ir_out_q;
  assign ir_pc    = ir_pc_q;
  assign ir_valid = ir_valid_q;
  assign IncPC    = incpc_q;
  assign fault    = fault_q;

endmodule
